// File: rtl/tuning_pkg.sv
// Shared types and constants for the cap-board tuning-code sequencer.
package tuning_pkg;

    localparam int unsigned CODE_W_DEFAULT = 7;
    // Boards latch after 4+ consecutive enable-high cycles; 6 adds margin.
    localparam int unsigned MIN_STROBE_CYC = 6;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD,
        GAP
    } state_t;

endpackage

// File: rtl/tuning_phase_timer.sv
// Loadable down-counter shared by every sequencer phase; zero_c marks the last cycle.
module tuning_phase_timer #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero_c
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    assign zero_c = (count == '0);

endmodule

// File: rtl/tuning_sequencer.sv
// Ramps the shared tuning-code bus toward a requested target in bounded steps,
// wrapping each step in setup / strobe / hold windows for the cap-board latches.
module tuning_sequencer
    import tuning_pkg::*;
#(
    parameter int unsigned CODE_W     = CODE_W_DEFAULT,
    parameter int unsigned SETUP_CYC  = 2,
    parameter int unsigned STROBE_CYC = 8,
    parameter int unsigned HOLD_CYC   = 2,
    parameter int unsigned GAP_CYC    = 16,
    parameter int unsigned MAX_STEP   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic [CODE_W-1:0] req_code,
    output logic              req_ready,
    output logic [CODE_W-1:0] tuning_code,
    output logic              enable,
    output logic              busy,
    output logic              done,
    output logic [CODE_W-1:0] current_code
);

    localparam int unsigned MAX_SS  = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
    localparam int unsigned MAX_HG  = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
    localparam int unsigned MAX_CYC = (MAX_SS > MAX_HG) ? MAX_SS : MAX_HG;
    localparam int unsigned TMR_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam int unsigned CODE_MAX = (1 << CODE_W) - 1;
    localparam int unsigned STEP_CAP = (MAX_STEP > CODE_MAX) ? CODE_MAX : MAX_STEP;
    localparam logic [CODE_W:0] STEP_LIM = (CODE_W + 1)'(STEP_CAP);

    if (STROBE_CYC < MIN_STROBE_CYC) begin : g_strobe_too_short
        $error("tuning_sequencer: STROBE_CYC below MIN_STROBE_CYC");
    end
    if (MAX_STEP < 1) begin : g_step_zero
        $error("tuning_sequencer: MAX_STEP must be at least 1");
    end
    if (SETUP_CYC < 1 || HOLD_CYC < 1 || GAP_CYC < 1) begin : g_phase_zero
        $error("tuning_sequencer: SETUP_CYC, HOLD_CYC and GAP_CYC must be at least 1");
    end

    state_t            state;
    logic [CODE_W-1:0] target;
    logic [CODE_W-1:0] next_code;

    logic [CODE_W-1:0] step_tgt_c;
    logic [CODE_W-1:0] next_c;
    logic [CODE_W:0]   diff_c;
    logic [CODE_W:0]   step_c;
    logic [CODE_W:0]   sum_c;
    logic              accept_c;
    logic              phase_end_c;
    logic              tmr_load_c;
    logic [TMR_W-1:0]  tmr_val_c;
    logic              tmr_zero_c;

    // Next ramp point; the extra bit keeps the difference from wrapping.
    always_comb begin
        step_tgt_c = (state == IDLE) ? req_code : target;
        diff_c     = '0;
        step_c     = '0;
        sum_c      = {1'b0, current_code};
        if (step_tgt_c > current_code) begin
            diff_c = {1'b0, step_tgt_c} - {1'b0, current_code};
            step_c = (diff_c > STEP_LIM) ? STEP_LIM : diff_c;
            sum_c  = {1'b0, current_code} + step_c;
        end else if (step_tgt_c < current_code) begin
            diff_c = {1'b0, current_code} - {1'b0, step_tgt_c};
            step_c = (diff_c > STEP_LIM) ? STEP_LIM : diff_c;
            sum_c  = {1'b0, current_code} - step_c;
        end
        next_c = sum_c[CODE_W] ? '1 : sum_c[CODE_W-1:0];
    end

    // Timer reloads on the edge that enters each phase with that phase's length - 1.
    always_comb begin
        accept_c    = req_valid && req_ready;
        phase_end_c = (state != IDLE) && tmr_zero_c;
        tmr_load_c  = accept_c || phase_end_c;
        tmr_val_c   = '0;
        case (state)
            IDLE, GAP: tmr_val_c = TMR_W'(SETUP_CYC - 1);
            SETUP:     tmr_val_c = TMR_W'(STROBE_CYC - 1);
            STROBE:    tmr_val_c = TMR_W'(HOLD_CYC - 1);
            HOLD:      tmr_val_c = TMR_W'(GAP_CYC - 1);
            default:   tmr_val_c = '0;
        endcase
    end

    tuning_phase_timer #(
        .W(TMR_W)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (tmr_load_c),
        .load_val(tmr_val_c),
        .zero_c  (tmr_zero_c)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            target       <= '0;
            next_code    <= '0;
            tuning_code  <= '0;
            enable       <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            req_ready    <= 1'b1;
            current_code <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept_c) begin
                        target      <= req_code;
                        next_code   <= next_c;
                        tuning_code <= next_c;
                        busy        <= 1'b1;
                        req_ready   <= 1'b0;
                        state       <= SETUP;
                    end
                end
                SETUP: begin
                    if (phase_end_c) begin
                        enable <= 1'b1;
                        state  <= STROBE;
                    end
                end
                STROBE: begin
                    if (phase_end_c) begin
                        enable <= 1'b0;
                        state  <= HOLD;
                    end
                end
                HOLD: begin
                    if (phase_end_c) begin
                        current_code <= next_code;
                        if (next_code == target) begin
                            done      <= 1'b1;
                            busy      <= 1'b0;
                            req_ready <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            state <= GAP;
                        end
                    end
                end
                GAP: begin
                    if (phase_end_c) begin
                        next_code   <= next_c;
                        tuning_code <= next_c;
                        state       <= SETUP;
                    end
                end
                default: begin
                    enable    <= 1'b0;
                    busy      <= 1'b0;
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tuning_sequencer.sv
// Directed bench for tuning_sequencer: vector table of ramps plus hand-written timing sequences.
module tb_tuning_sequencer;

    localparam int unsigned HOLD_CYC = 2;
    localparam int unsigned SETUP_CYC = 2;

    logic       clk;
    logic       rst_n;
    logic       req_valid;
    logic [6:0] req_code;
    logic       req_ready;
    logic [6:0] tuning_code;
    logic       enable;
    logic       busy;
    logic       done;
    logic [6:0] current_code;

    tuning_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_code    (req_code),
        .req_ready   (req_ready),
        .tuning_code (tuning_code),
        .enable      (enable),
        .busy        (busy),
        .done        (done),
        .current_code(current_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int req;
        int n;
        int codes[16];
    } vec_t;

    vec_t vecs[7];

    int strobe_codes[$];
    int high_q[$];
    int low_q[$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Strobe monitor: records strobed codes and window lengths, flags illegal code changes.
    logic prev_en   = 1'b0;
    logic [6:0] prev_code = '0;
    int   low_run   = 100;
    int   high_run  = 0;
    int   since_chg = 100;

    always @(negedge clk) begin
        if (!rst_n) begin
            low_run   = 100;
            high_run  = 0;
            since_chg = 100;
        end else begin
            if (tuning_code != prev_code) begin
                since_chg = 0;
                check("code_change_window", int'(!enable && low_run >= int'(HOLD_CYC)), 1);
            end else begin
                since_chg++;
            end
            if (enable && !prev_en) begin
                strobe_codes.push_back(int'(tuning_code));
                low_q.push_back(low_run);
                check("setup_before_rise", int'(since_chg >= int'(SETUP_CYC)), 1);
                high_run = 1;
            end else if (enable) begin
                high_run++;
            end else if (prev_en) begin
                high_q.push_back(high_run);
                low_run = 1;
            end else begin
                low_run++;
            end
        end
        prev_en   = enable;
        prev_code = tuning_code;
    end

    task automatic start_request(input int code);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (req_ready) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!seen) check("ready_timeout", 0, 1);
        strobe_codes.delete();
        high_q.delete();
        low_q.delete();
        req_valid = 1'b1;
        req_code  = 7'(code);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("busy_after_accept", int'(busy), 1);
    endtask

    task automatic wait_done(input int code);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            check("done_timeout", 0, 1);
        end else begin
            check("current_at_done", int'(current_code), code);
            check("ready_at_done", int'(req_ready), 1);
            check("busy_at_done", int'(busy), 0);
            @(negedge clk);
            check("done_single_pulse", int'(done), 0);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_code  = '0;

        vecs[0] = '{20, 3, '{8, 16, 20, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0}};
        vecs[1] = '{3, 3, '{12, 4, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0}};
        vecs[2] = '{0, 1, '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0}};
        vecs[3] = '{120, 15, '{8, 16, 24, 32, 40, 48, 56, 64, 72, 80, 88, 96, 104, 112, 120, 0}};
        vecs[4] = '{127, 1, '{127, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0}};
        vecs[5] = '{0, 16, '{119, 111, 103, 95, 87, 79, 71, 63, 55, 47, 39, 31, 23, 15, 7, 0}};
        vecs[6] = '{7, 1, '{7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0}};

        // Reset held for three cycles.
        repeat (3) @(negedge clk);
        check("rst_tuning_code", int'(tuning_code), 0);
        check("rst_enable", int'(enable), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_current", int'(current_code), 0);
        check("rst_ready", int'(req_ready), 1);
        rst_n = 1'b1;
        @(negedge clk);

        // Single step 0 -> 5, cycle-exact strobe and done timing from E0.
        req_valid = 1'b1;
        req_code  = 7'd5;
        @(posedge clk);
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            req_valid = 1'b0;
            check("single_code", int'(tuning_code), 5);
            check("single_enable", int'(enable), int'(k >= 2 && k < 10));
            check("single_done", int'(done), int'(k == 12));
            if (k == 0) check("single_ready_low", int'(req_ready), 0);
        end
        check("single_current", int'(current_code), 5);

        // Reset in the middle of a strobe aborts at once.
        start_request(100);
        for (int i = 0; i < 50 && !enable; i++) @(negedge clk);
        check("midrst_in_strobe", int'(enable), 1);
        check("midrst_code", int'(tuning_code), 13);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_enable", int'(enable), 0);
        check("midrst_tuning_code", int'(tuning_code), 0);
        check("midrst_current", int'(current_code), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_ready", int'(req_ready), 1);
        rst_n = 1'b1;
        @(negedge clk);

        // Ramp vectors applied back to back.
        for (int v = 0; v < 7; v++) begin
            start_request(vecs[v].req);
            wait_done(vecs[v].req);
            check("n_strobes", strobe_codes.size(), vecs[v].n);
            for (int i = 0; i < vecs[v].n && i < strobe_codes.size(); i++) begin
                check("strobe_code", strobe_codes[i], vecs[v].codes[i]);
                if (i < high_q.size()) check("strobe_width", high_q[i], 8);
                if (i > 0) check("gap_low_cycles", low_q[i], 20);
                else       check("first_low_min", int'(low_q[i] >= 4), 1);
            end
        end

        // Refresh at 7 with a competing request that must be ignored.
        start_request(7);
        for (int i = 0; i < 5; i++) begin
            req_valid = 1'b1;
            req_code  = 7'd50;
            @(negedge clk);
            check("busy_ignore_ready", int'(req_ready), 0);
            check("busy_ignore_code", int'(tuning_code), 7);
        end
        req_valid = 1'b0;
        wait_done(7);
        check("refresh_n_strobes", strobe_codes.size(), 1);
        if (strobe_codes.size() > 0) check("refresh_code", strobe_codes[0], 7);
        repeat (3) @(negedge clk);
        check("refresh_no_new_seq", int'(busy), 0);
        check("refresh_code_kept", int'(tuning_code), 7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/tuning_sequencer.md
# tuning_sequencer

Master-side controller that sequences global tuning-code updates to the cap boards. It accepts a target tuning code from the upstream tuning logic and drives the shared `tuning_code` bus and `enable` strobe seen by every cap-board decoder. Each update is ramped in bounded steps, with guaranteed setup, strobe-width and hold windows. A board therefore never samples a changing code, and the capacitor bank never jumps by more than `MAX_STEP` IDs per update.

## Interface
- `CODE_W`, 7: width of the tuning code.
- `SETUP_CYC`, 2: cycles the code is stable with `enable` low before the strobe.
- `STROBE_CYC`, 8: cycles `enable` is held high. Must be ≥ `MIN_STROBE_CYC` (6); a smaller value is an elaboration error.
- `HOLD_CYC`, 2: cycles the code is held after `enable` falls.
- `GAP_CYC`, 16: extra `enable`-low cycles between consecutive ramp steps.
- `MAX_STEP`, 8: largest code change per strobe. Must be ≥ 1.

Ports:
- `clk`, in, 1: system clock. Single clock domain.
- `rst_n`, in, 1: synchronous, active-low reset.
- `req_valid`, in, 1: upstream target code valid.
- `req_code`, in, `CODE_W`: requested target code.
- `req_ready`, out, 1: high only in IDLE.
- `tuning_code`, out, `CODE_W`: code bus to the cap boards. Registered.
- `enable`, out, 1: board latch strobe. Registered.
- `busy`, out, 1: high in any state other than IDLE.
- `done`, out, 1: one-cycle pulse when the target has been reached.
- `current_code`, out, `CODE_W`: last code actually strobed to the boards.

## Operation
- **Reset** (`rst_n` low at an edge), effective the next cycle:
  - `tuning_code` = 0 (all capacitors off, baseload only).
  - `enable` = 0, `busy` = 0, `done` = 0, `current_code` = 0.
  - `req_ready` = 1, state = IDLE.
- Reset mid-sequence aborts immediately. `enable` is never left high.
- **States:**
  - IDLE: `req_ready` = 1. On `req_valid` && `req_ready`, latch `target` = `req_code` and compute `next`, then go to SETUP.
  - SETUP: `tuning_code` = `next`, `enable` = 0. Lasts `SETUP_CYC` cycles, then STROBE.
  - STROBE: `enable` = 1, code unchanged. Lasts `STROBE_CYC` cycles, then HOLD.
  - HOLD: `enable` = 0, code unchanged. Lasts `HOLD_CYC` cycles. On exit, `current_code` ← `next`.
    - If `next` == `target`: pulse `done` and return to IDLE.
    - Otherwise: go to GAP.
  - GAP: `enable` = 0. Lasts `GAP_CYC` cycles. Recompute `next`, then go to SETUP.
- **Step rule:**
  - If `target` > `current`: `next` = `current` + min(`target` − `current`, `MAX_STEP`).
  - If `target` < `current`: symmetric, stepping down.
  - Compute the difference at `CODE_W`+1 bits so there is no wrap-around. Codes saturate within 0..2^`CODE_W`−1.
- `target` == `current_code` is a refresh request: exactly one SETUP/STROBE/HOLD with an unchanged code, then `done`.
- `req_valid` while busy is ignored and not queued. Upstream must hold `req_valid` until it sees `req_ready`.
- `tuning_code` changes only on the SETUP entry edge, never while `enable` = 1 or during HOLD.

## Timing
- Handshake at edge E0 (the state moves to SETUP).
- Code change: `tuning_code` shows `next` from E0.
- Strobe edges: `enable` rises at E0+`SETUP_CYC` and falls at E0+`SETUP_CYC`+`STROBE_CYC`.
- Single-step latency: `done` is high for the one cycle starting at E0+`SETUP_CYC`+`STROBE_CYC`+`HOLD_CYC`. `req_ready` returns high in that same cycle.
- Multi-step: each extra step adds `GAP_CYC`+`SETUP_CYC`+`STROBE_CYC`+`HOLD_CYC` cycles.
- Minimum `enable`-low time between strobes is `HOLD_CYC`+`GAP_CYC`+`SETUP_CYC`.
- A new request accepted in the `done` cycle is legal. Back-to-back requests still give ≥ `HOLD_CYC`+`SETUP_CYC` low cycles between strobes.

## Structure
- Package `tuning_pkg` holds:
  - the `CODE_W` default;
  - `MIN_STROBE_CYC` = 6 (boards latch after 4+ consecutive enable-high cycles, plus margin);
  - the state enum: IDLE, SETUP, STROBE, HOLD, GAP.
- Sub-module `tuning_phase_timer`: a loadable down-counter with a terminal-count flag, reused for every phase duration. It is sized to the maximum of the phase parameters.
- Step computation is combinational inside `tuning_sequencer`.

## Test plan
- **Reset:** hold `rst_n` low for 3 cycles → all outputs 0, `req_ready` = 1. Assert reset mid-STROBE → `enable` = 0 and `tuning_code` = 0 the next cycle.
- **Single step (defaults):** request 5 from 0 → `tuning_code` = 5 from E0, `enable` high exactly 8 cycles starting at E0+2, `done` pulse at E0+12, `current_code` = 5.
- **Ramp up:** request 20 from 0 → strobed codes 8, 16, 20, with ≥ 20 low cycles between strobes, then a single `done`.
- **Ramp down:** request 3 from 20 → strobed codes 12, 4, 3. No code change while `enable` = 1.
- **Refresh and busy-ignore:** request 7 while at 7 → one strobe with code 7, then `done`. A `req_valid` with code 50 during this sequence is not accepted (`req_ready` = 0) and causes no code change.
- **Boundaries:** request 127 from 120 → single step to 127. Then request 0 → 119, 111, … in steps of 8 ending at 0, with no wrap-around. Elaborating with `STROBE_CYC` = 4 fails.
